// File: rtl/mc_vec_controller_if.sv
// mc_vec_controller_if: instruction/flag inputs and write-enable/select outputs between controller (master) and datapath (slave)
interface mc_vec_controller_if #(
  parameter int NLANES = 4,
  parameter int LANE_W = $clog2(NLANES)
);
  logic [31:12] Instr;
  logic [3:0] ALUFlags;
  logic PCWrite, IRWrite, RegWrite, MemWrite, VecWrite, VecIdxWrite;
  logic AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl;
  logic [LANE_W-1:0] LaneIdx;
  logic Busy;
  modport master (
    input Instr, ALUFlags,
    output PCWrite, IRWrite, RegWrite, MemWrite, VecWrite, VecIdxWrite,
    output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, LaneIdx, Busy
  );
  modport slave (
    output Instr, ALUFlags,
    input PCWrite, IRWrite, RegWrite, MemWrite, VecWrite, VecIdxWrite,
    input AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, LaneIdx, Busy
  );
endinterface

// File: rtl/mc_vec_controller.sv
// mc_vec_controller: multicycle ARM-style control FSM; vector lane iteration enabled by MC_VEC_CONTROLLER_VEC_EN
module mc_vec_controller #(
  parameter int NLANES = 4,
  parameter int LANE_W = $clog2(NLANES)
) (
  input logic clk,
  input logic reset,
  mc_vec_controller_if.master bus
);
  localparam logic [3:0] AND_OP = 4'b0000, SUB_OP = 4'b0010, ADD_OP = 4'b0100, CMP_OP = 4'b1010, ORR_OP = 4'b1100;
  typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, VEXEC, VIDX} state_t;
  state_t state, eff, vec_next;
  logic [31:12] ir;
  logic [3:0] flags, cmd, alu_dec;
  logic n, z, c, v, cond_ex, is_cmp, rd_pc, unused_rn;
  assign eff = reset ? FETCH : state;
  assign cmd = ir[24:21];
  assign {n, z, c, v} = flags;
  assign is_cmp = cmd == CMP_OP;
  assign rd_pc = ir[15:12] == 4'hf;
  assign unused_rn = ^ir[19:16];
  assign alu_dec = cmd inside {ADD_OP, SUB_OP, AND_OP, ORR_OP, CMP_OP} ? cmd : ADD_OP;
  always_comb
    case (ir[31:28])
      4'h0: cond_ex = z;
      4'h1: cond_ex = !z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = !c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = !n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = !v;
      4'h8: cond_ex = c && !z;
      4'h9: cond_ex = !c || z;
      4'ha: cond_ex = n == v;
      4'hb: cond_ex = n != v;
      4'hc: cond_ex = !z && n == v;
      4'hd: cond_ex = z || n != v;
      4'he: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
`ifdef MC_VEC_CONTROLLER_VEC_EN
  logic [LANE_W-1:0] lane;
  logic last;
  assign last = lane == LANE_W'(NLANES - 1);
  assign vec_next = ir[25] ? VIDX : VEXEC;
`else
  assign vec_next = FETCH;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      ir <= '0;
      flags <= '0;
`ifdef MC_VEC_CONTROLLER_VEC_EN
      lane <= '0;
`endif
    end else begin
      if (state == FETCH) ir <= bus.Instr;
      if (state == ALUWB && cond_ex && (ir[20] || is_cmp)) flags <= bus.ALUFlags;
`ifdef MC_VEC_CONTROLLER_VEC_EN
      lane <= (state != VEXEC || last) ? '0 : lane + 1'b1;
`endif
      case (state)
        FETCH: state <= DECODE;
        DECODE: state <= ir[27:26] == 2'b00 ? (ir[25] ? EXECI : EXECR) :
                         ir[27:26] == 2'b01 ? MEMADR :
                         ir[27:26] == 2'b10 ? BRANCH : vec_next;
        MEMADR: state <= ir[20] ? MEMRD : MEMWR;
        MEMRD: state <= MEMWB;
        EXECR, EXECI: state <= ALUWB;
`ifdef MC_VEC_CONTROLLER_VEC_EN
        VEXEC: state <= last ? FETCH : VEXEC;
`endif
        default: state <= FETCH;
      endcase
    end
  assign bus.Busy = eff != FETCH;
  assign bus.IRWrite = !reset && state == FETCH;
  assign bus.PCWrite = !reset && (state == FETCH || cond_ex && (state == BRANCH || state == ALUWB && rd_pc && !is_cmp));
  assign bus.RegWrite = cond_ex && (eff == MEMWB || eff == ALUWB && !rd_pc && !is_cmp);
  assign bus.MemWrite = cond_ex && eff == MEMWR;
  assign bus.AdrSrc = eff inside {MEMRD, MEMWR};
  assign bus.ALUSrcA = eff inside {FETCH, DECODE};
  assign bus.ALUSrcB = eff inside {FETCH, DECODE} ? 2'b10 : eff inside {MEMADR, EXECI, BRANCH} ? 2'b01 : 2'b00;
  assign bus.ResultSrc = eff inside {FETCH, DECODE, BRANCH} ? 2'b10 : eff == MEMWB ? 2'b01 : 2'b00;
  assign bus.ImmSrc = ir[27:26];
  assign bus.RegSrc = {ir[27:26] == 2'b01, ir[27:26] == 2'b10};
  assign bus.ALUControl = eff inside {EXECR, EXECI, VEXEC} ? alu_dec : ADD_OP;
`ifdef MC_VEC_CONTROLLER_VEC_EN
  assign bus.VecWrite = cond_ex && eff == VEXEC;
  assign bus.VecIdxWrite = cond_ex && eff == VIDX;
  assign bus.LaneIdx = eff == VEXEC ? lane : '0;
`else
  assign bus.VecWrite = 1'b0;
  assign bus.VecIdxWrite = 1'b0;
  assign bus.LaneIdx = LANE_W'(0);
`endif
endmodule

// File: doc/mc_vec_controller.md
MC_VEC_CONTROLLER -- requirements
Module: mc_vec_controller

Interface
REQ-001 Parameter NLANES, default 4, meaning vector lanes iterated per vector instruction; legal values are powers of two from 2 to 16.
REQ-002 Parameter LANE_W, default $clog2(NLANES), meaning LaneIdx width.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Instr  in  [31:12]  instruction fields: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]; sampled only while IRWrite is high.
REQ-006 ALUFlags  in  [3:0]  {N,Z,C,V} from the ALU in the current cycle.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite, VecWrite, VecIdxWrite  out  1 each  write enables.
REQ-008 AdrSrc, ALUSrcA  out  1 each; ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  [1:0] each; ALUControl  out  [3:0]  datapath selects.
REQ-009 LaneIdx  out  [LANE_W-1:0]  active vector lane.
REQ-010 Busy  out  1  high whenever the state is not FETCH.

Function
REQ-011 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, VEXEC, VIDX.
REQ-012 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1; next state DECODE.
REQ-013 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10; next state by Op: 00 with Funct[5]=0 -> EXECR, 00 with Funct[5]=1 -> EXECI, 01 -> MEMADR, 10 -> BRANCH, 11 -> VEXEC if Funct[5]=0 or VIDX if Funct[5]=1.
REQ-014 MEMADR: next state MEMRD if Funct[0]=1, else MEMWR. MEMRD -> MEMWB -> FETCH. MEMWR -> FETCH. EXECR/EXECI -> ALUWB -> FETCH. BRANCH -> FETCH. VIDX -> FETCH.
REQ-015 Cycle counts: LDR 5, STR 4, data-processing 4, B 3, VIDX 3, vector op NLANES+2.
REQ-016 ALUControl in EXECR/EXECI/VEXEC is decoded from Funct[4:1] as: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010; all other codes give ADD. ALUControl is ADD in every other state.
REQ-017 CondEx is evaluated against the registered Flags using standard ARM conditions (0000-1110); Cond=1111 gives CondEx=0.
REQ-018 RegWrite is asserted in MEMWB and ALUWB only when CondEx=1. It is never asserted for CMP, or when Rd=15 for data-processing; Rd=15 instead asserts PCWrite.
REQ-019 MemWrite is asserted in MEMWR only when CondEx=1. PCWrite is asserted in BRANCH only when CondEx=1.
REQ-020 The Flags register loads ALUFlags at the end of an ALUWB cycle only when Funct[0]=1 (or the instruction is CMP) and CondEx=1.
REQ-021 VEXEC: the lane counter starts at 0 and increments each cycle. LaneIdx equals the counter. VecWrite equals CondEx. Exit to FETCH on the cycle where the counter equals NLANES-1, and the counter returns to 0.
REQ-022 VIDX: VecIdxWrite equals CondEx for one cycle.
REQ-023 A failed condition never alters the state sequence or latency; only write enables are suppressed.
REQ-024 LaneIdx is 0 outside VEXEC. Condition is evaluated from Flags registered before the instruction, so a flag update in cycle N affects only later instructions.

Reset
REQ-025 While reset is high at a clock edge: state becomes FETCH, lane counter 0, Flags 0000.
REQ-026 While reset is high, all write enables (PCWrite, IRWrite, RegWrite, MemWrite, VecWrite, VecIdxWrite) are forced to 0 and Busy is 0. All other outputs take their FETCH values.
REQ-027 Reset asserted mid-instruction (including mid-VEXEC) aborts the instruction with no further writes; the first post-reset cycle is FETCH.

Configuration
REQ-028 Macro MC_VEC_CONTROLLER_VEC_EN: when defined, REQ-013 Op=11 handling, VEXEC, VIDX and LaneIdx behave as specified.
REQ-029 When MC_VEC_CONTROLLER_VEC_EN is undefined: Op=11 goes from DECODE directly to FETCH (2 cycles, no writes), VecWrite and VecIdxWrite are tied to 0, and LaneIdx is tied to 0.

Verification
REQ-030 Reset held 2 cycles, then released -> FETCH with PCWrite=1 and IRWrite=1, Busy=0; every write enable is 0 during reset.
REQ-031 ADDS (Cond=1110, Op=00, Funct=001001, Rd=3) -> exactly 4 cycles, RegWrite=1 in cycle 4, Flags load ALUFlags=0100; a following BEQ (Cond=0000) asserts PCWrite in BRANCH.
REQ-032 STR with Cond=0001 (NE) while Z=1 -> 4-cycle sequence with MemWrite=0 throughout.
REQ-033 Vector op with NLANES=4, Cond=1110 -> VecWrite=1 for 4 consecutive cycles, LaneIdx 0,1,2,3, then FETCH; repeat with NLANES=8 -> 10-cycle instruction.
REQ-034 reset asserted at LaneIdx=2 -> no VecWrite on the next edge, then FETCH with LaneIdx=0.
REQ-035 Build without MC_VEC_CONTROLLER_VEC_EN, issue Op=11 -> 2 cycles, no write enables, next FETCH.
